// File: rtl/sbox_layer_serial_pkg.sv
// Shared definitions for the serial S-box layer.
//   SBOX_W       word width of one S-box lane
//   state_t      layer FSM states
//   sbox_ref()   behavioural reference of the 6-bit S-box. It computes the same
//                power map as gf64_pow52_core with a plain shift-and-add field
//                multiply and 52 repeated multiplications.
//
// Tower field used throughout:
//   GF(8)  = GF(2)[w] / (w^3 + w + 1)
//   GF(64) = GF(8)[y] / (y^2 + y + 1)   (irreducible because Tr(1) = 1 in GF(8))
//   A 6-bit tower element is {a1, a0} = a1*y + a0. bits [5:3] hold a1 and bits [2:0] hold a0.
package sbox_layer_serial_pkg;

  localparam int SBOX_W  = 6;
  localparam int POW_EXP = 52;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Input basis change into tower coordinates. Row i is the mask of input bits
  // that are XORed to form tower bit i.
  localparam logic [5:0][5:0] M_IN_ROWS = {
    6'b100000, 6'b010000, 6'b001000, 6'b100110, 6'b010010, 6'b001001
  };

  // Basis change out of tower coordinates, fused with the output linear mix.
  // The mix moves the image of 1 to 0x16. For that reason S(1) != 1.
  localparam logic [5:0][5:0] M_OUT_ROWS = {
    6'b100000, 6'b010001, 6'b101000, 6'b000101, 6'b000011, 6'b001010
  };

  function automatic logic [2:0] gf8_mul_ref(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    logic [2:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[1:0], 1'b0} ^ (aa[2] ? 3'b011 : 3'b000);
    end
    return r;
  endfunction

  function automatic logic [5:0] gf64_mul_ref(input logic [5:0] a, input logic [5:0] b);
    logic [2:0] hh, hl, lh, ll;
    hh = gf8_mul_ref(a[5:3], b[5:3]);
    hl = gf8_mul_ref(a[5:3], b[2:0]);
    lh = gf8_mul_ref(a[2:0], b[5:3]);
    ll = gf8_mul_ref(a[2:0], b[2:0]);
    return {hh ^ hl ^ lh, hh ^ ll};
  endfunction

  function automatic logic [5:0] sbox_ref(input logic [5:0] x);
    logic [5:0] t, r, y;
    for (int i = 0; i < 6; i++) t[i] = ^(x & M_IN_ROWS[i]);
    r = 6'b000001;
    for (int k = 0; k < POW_EXP; k++) r = gf64_mul_ref(r, t);
    for (int i = 0; i < 6; i++) y[i] = ^(r & M_OUT_ROWS[i]);
    return y;
  endfunction

endpackage

// File: rtl/gf64_pow52_core.sv
// Combinational 6-bit S-box core: S(x) = Mout( (Min x)^52 ) in GF((2^3)^2).
//   x  in   6   S-box input word
//   y  out  6   substituted word
// The exponent is built as x^32 * x^16 * x^4. Squarings are GF(2)-linear, so
// the design needs only two full tower multipliers.
module gf64_pow52_core (
  input  logic [5:0] x,
  output logic [5:0] y
);

  function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
    logic p0, p1, p2, p3, p4;
    p0 = a[0] & b[0];
    p1 = (a[0] & b[1]) ^ (a[1] & b[0]);
    p2 = (a[0] & b[2]) ^ (a[1] & b[1]) ^ (a[2] & b[0]);
    p3 = (a[1] & b[2]) ^ (a[2] & b[1]);
    p4 = a[2] & b[2];
    // w^3 = w + 1, w^4 = w^2 + w
    return {p2 ^ p4, p1 ^ p3 ^ p4, p0 ^ p3};
  endfunction

  function automatic logic [2:0] gf8_sq(input logic [2:0] a);
    return {a[1] ^ a[2], a[2], a[0]};
  endfunction

  // Karatsuba: the cross term comes from one extra multiply of the sums.
  function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
    logic [2:0] h, l, m;
    h = gf8_mul(a[5:3], b[5:3]);
    l = gf8_mul(a[2:0], b[2:0]);
    m = gf8_mul(a[5:3] ^ a[2:0], b[5:3] ^ b[2:0]);
    return {m ^ l, h ^ l};
  endfunction

  // (a1 y + a0)^2 = a1^2 y + (a1^2 + a0^2), since y^2 = y + 1
  function automatic logic [5:0] gf64_sq(input logic [5:0] a);
    logic [2:0] s1;
    s1 = gf8_sq(a[5:3]);
    return {s1, s1 ^ gf8_sq(a[2:0])};
  endfunction

  logic [5:0] t, x2, x4, x8, x16, x32, x48, u;

  assign t[0] = x[0] ^ x[3];
  assign t[1] = x[1] ^ x[4];
  assign t[2] = x[2] ^ x[5] ^ x[1];
  assign t[3] = x[3];
  assign t[4] = x[4];
  assign t[5] = x[5];

  assign x2  = gf64_sq(t);
  assign x4  = gf64_sq(x2);
  assign x8  = gf64_sq(x4);
  assign x16 = gf64_sq(x8);
  assign x32 = gf64_sq(x16);
  assign x48 = gf64_mul(x32, x16);
  assign u   = gf64_mul(x48, x4);

  assign y[0] = u[1] ^ u[3];
  assign y[1] = u[0] ^ u[1];
  assign y[2] = u[0] ^ u[2];
  assign y[3] = u[3] ^ u[5];
  assign y[4] = u[0] ^ u[4];
  assign y[5] = u[5];

endmodule

// File: rtl/sbox_layer_serial.sv
// Serial S-box layer. An NWORDS x 6-bit state is rotated word by word through
// one gf64_pow52_core.
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input state valid
//   in_ready   layer idle and able to accept (combinational)
//   in_state   input state, word i = in_state[6*i+5:6*i]
//   out_valid  out_state holds a finished result
//   out_ready  downstream accepts out_state
//   out_state  substituted state, word i = S(input word i)
//
// state | meaning
// IDLE  | waiting for a state; in_ready = 1
// RUN   | one word per cycle through the core, rotating right
// DONE  | result held; out_valid raised one cycle after entry and held until out_ready
module sbox_layer_serial
  import sbox_layer_serial_pkg::*;
#(
  parameter int NWORDS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*SBOX_W-1:0] in_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*SBOX_W-1:0] out_state
);

  localparam int W  = NWORDS * SBOX_W;
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic            ov_q, ov_d;
  logic [W-1:0]    shifted;
  logic [SBOX_W-1:0] sbox_out;

  gf64_pow52_core u_core (
    .x (sreg_q[SBOX_W-1:0]),
    .y (sbox_out)
  );

  if (NWORDS == 1) begin : g_one_word
    assign shifted = sbox_out;
  end else begin : g_multi_word
    assign shifted = {sbox_out, sreg_q[W-1:SBOX_W]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_state;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end else begin
          ov_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = ov_q;
  assign out_state = sreg_q;

endmodule
